// File: rtl/gate_response_checker.sv
// Checks a combinational gate-under-test against its select map, counting samples and mismatches.
// Optional macro CHECKER_COVERAGE_EN adds cov_map and makes pass require full {sel,a,b} coverage.
module gate_response_checker #(
   parameter int ERR_W = 6,
   parameter int N_VEC = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             valid,
   input  logic [2:0]       sel,
   input  logic             a,
   input  logic             b,
   input  logic             out,
   input  logic             last,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [5:0]       smp_cnt,
`ifdef CHECKER_COVERAGE_EN
   output logic [31:0]      cov_map,
`endif
   output logic             mismatch
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam logic [5:0]       LAST_SMP = 6'(N_VEC);
   localparam logic [ERR_W-1:0] ERR_MAX  = '1;

   state_t           state_q, state_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic             mismatch_q, mismatch_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic [5:0]       smp_cnt_q, smp_cnt_d;
   logic             exp_val;
   logic             cov_ok;

`ifdef CHECKER_COVERAGE_EN
   logic [31:0] cov_map_q, cov_map_d;
   assign cov_ok = &cov_map_d;
`else
   assign cov_ok = 1'b1;
`endif

   always_comb begin
      exp_val = 1'b0;
      unique case (sel)
         3'b000: exp_val = ~(a & b);
         3'b001: exp_val = a & b;
         3'b010: exp_val = a | b;
         3'b011: exp_val = ~(a | b);
         3'b100: exp_val = a ^ b;
         3'b101: exp_val = ~(a ^ b);
         3'b110: exp_val = ~a;
         3'b111: exp_val = ~a;
         default: exp_val = 1'b0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      done_d     = done_q;
      pass_d     = pass_q;
      err_cnt_d  = err_cnt_q;
      smp_cnt_d  = smp_cnt_q;
      mismatch_d = 1'b0;
`ifdef CHECKER_COVERAGE_EN
      cov_map_d  = cov_map_q;
`endif
      unique case (state_q)
         IDLE, DONE: begin
            // valid is ignored here, even alongside start
            if (start) begin
               state_d   = RUN;
               busy_d    = 1'b1;
               done_d    = 1'b0;
               pass_d    = 1'b0;
               err_cnt_d = '0;
               smp_cnt_d = '0;
`ifdef CHECKER_COVERAGE_EN
               cov_map_d = '0;
`endif
            end
         end
         RUN: begin
            if (valid) begin
               mismatch_d = out ^ exp_val;
               if ((out ^ exp_val) && (err_cnt_q != ERR_MAX))
                  err_cnt_d = err_cnt_q + 1'b1;
               if (smp_cnt_q != LAST_SMP)
                  smp_cnt_d = smp_cnt_q + 6'd1;
`ifdef CHECKER_COVERAGE_EN
               cov_map_d[{sel, a, b}] = 1'b1;
`endif
               if (last || (smp_cnt_q + 6'd1 == LAST_SMP)) begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_cnt_d == '0) &&
                            (smp_cnt_d != 6'd0) && cov_ok;
               end
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         err_cnt_q  <= '0;
         smp_cnt_q  <= '0;
         mismatch_q <= 1'b0;
`ifdef CHECKER_COVERAGE_EN
         cov_map_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         err_cnt_q  <= err_cnt_d;
         smp_cnt_q  <= smp_cnt_d;
         mismatch_q <= mismatch_d;
`ifdef CHECKER_COVERAGE_EN
         cov_map_q  <= cov_map_d;
`endif
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign pass     = pass_q;
   assign err_cnt  = err_cnt_q;
   assign smp_cnt  = smp_cnt_q;
   assign mismatch = mismatch_q;
`ifdef CHECKER_COVERAGE_EN
   assign cov_map  = cov_map_q;
`endif

endmodule

// File: tb/tb_gate_response_checker.sv
// Scoreboard bench for gate_response_checker (ERR_W=4 so saturation is reachable).
// Follows CHECKER_COVERAGE_EN when the build defines it.
module tb_gate_response_checker;

   logic       clk = 1'b0;
   logic       rst, start, valid, a, b, out, last;
   logic [2:0] sel;
   logic       busy, done, pass, mismatch;
   logic [3:0] err_cnt;
   logic [5:0] smp_cnt;
`ifdef CHECKER_COVERAGE_EN
   logic [31:0] cov_map;
`endif

   gate_response_checker #(.ERR_W(4), .N_VEC(32)) dut (
      .clk(clk), .rst(rst), .start(start), .valid(valid),
      .sel(sel), .a(a), .b(b), .out(out), .last(last),
      .busy(busy), .done(done), .pass(pass),
      .err_cnt(err_cnt), .smp_cnt(smp_cnt),
`ifdef CHECKER_COVERAGE_EN
      .cov_map(cov_map),
`endif
      .mismatch(mismatch)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_err = 0;
   // truth table indexed by {sel,a,b}
   logic [31:0] tt = 32'h3396_1E87;
   bit          mq[$];

   int          m_st;
   logic [3:0]  m_err;
   int          m_smp;
   logic        m_pass;
   logic [31:0] m_cov;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_outs();
      bit em;
      em = 1'b0;
      if (mq.size() == 0) check("sb_empty", 32'd1, 32'd0);
      else em = mq.pop_front();
      check("mismatch", 32'(mismatch), 32'(em));
      check("busy", 32'(busy), 32'(m_st == 1));
      check("done", 32'(done), 32'(m_st == 2));
      check("pass", 32'(pass), 32'((m_st == 2) && m_pass));
      check("err_cnt", 32'(err_cnt), 32'(m_err));
      check("smp_cnt", 32'(smp_cnt), 32'(m_smp));
`ifdef CHECKER_COVERAGE_EN
      check("cov_map", cov_map, m_cov);
`endif
   endtask

   task automatic cyc(input logic st, input logic v, input logic [2:0] s,
                      input logic ia, input logic ib, input logic flip,
                      input logic l);
      logic [4:0] idx;
      bit         mm;
      idx   = {s, ia, ib};
      mm    = 1'b0;
      start = st; valid = v; sel = s; a = ia; b = ib;
      out   = tt[idx] ^ flip; last = l;
      if (m_st != 1) begin
         if (st) begin
            m_st = 1; m_err = 0; m_smp = 0; m_pass = 0; m_cov = 0;
         end
      end else if (v) begin
         mm = flip;
         if (flip && m_err != 4'd15) m_err = m_err + 4'd1;
         if (m_smp < 32) m_smp++;
         m_cov[idx] = 1'b1;
         if (l || m_smp == 32) begin
            m_st   = 2;
            m_pass = (m_err == 0) && (m_smp > 0);
`ifdef CHECKER_COVERAGE_EN
            if (m_cov != 32'hFFFF_FFFF) m_pass = 1'b0;
`endif
         end
      end
      mq.push_back(mm);
      @(posedge clk);
      #1;
      check_outs();
   endtask

   task automatic do_reset();
      start = 0; valid = 0; sel = 0; a = 0; b = 0; out = 0; last = 0;
      rst = 1'b1;
      #2;
      mq.delete();
      m_st = 0; m_err = 0; m_smp = 0; m_pass = 0; m_cov = 0;
      mq.push_back(1'b0);
      check_outs();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic sweep(input int flip_idx, input bit flip_all);
      logic [4:0] k;
      cyc(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 32; i++) begin
         k = 5'(i);
         cyc(0, 1, k[4:2], k[1], k[0], flip_all || (i == flip_idx), 0);
      end
   endtask

   initial begin
      logic [4:0] k;
      logic       rs, rv, rf, rl;
      do_reset();
      // exhaustive correct sweep ends on sample 32
      sweep(-1, 0);
      check("sweep_done", 32'(done), 32'd1);
      check("sweep_smp", 32'(smp_cnt), 32'd32);
      check("sweep_err", 32'(err_cnt), 32'd0);
      check("sweep_pass", 32'(pass), 32'd1);
      // one wrong response at sel=100 a=1 b=0
      sweep(18, 0);
      check("one_err", 32'(err_cnt), 32'd1);
      check("one_pass", 32'(pass), 32'd0);
      // all wrong: saturate
      sweep(-1, 1);
      check("sat_err", 32'(err_cnt), 32'd15);
      check("sat_pass", 32'(pass), 32'd0);
      // short run ended by last
      cyc(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         k = 5'(i * 3);
         cyc(0, 1, k[4:2], k[1], k[0], 0, i == 4);
      end
      check("last_smp", 32'(smp_cnt), 32'd5);
      // hold in DONE with valid ignored
      for (int i = 0; i < 3; i++) cyc(0, 1, 3'd2, 1, 1, 1, 0);
      // start in RUN, valid gaps
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 3'd1, 1, 1, 0, 0);
      cyc(0, 0, 3'd1, 0, 1, 1, 0);
      cyc(1, 1, 3'd4, 0, 1, 1, 0);
      cyc(1, 0, 3'd4, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 3'd6, 0, 0, 0, 1);
      check("gap_smp", 32'(smp_cnt), 32'd3);
      check("gap_err", 32'(err_cnt), 32'd1);
      // start+valid in DONE restarts without sampling
      cyc(1, 1, 3'd0, 0, 0, 1, 0);
      check("restart_busy", 32'(busy), 32'd1);
      check("restart_smp", 32'(smp_cnt), 32'd0);
      // rst mid-run, then valid without start
      cyc(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         k = 5'(i);
         cyc(0, 1, k[4:2], k[1], k[0], i == 3, 0);
      end
      do_reset();
      for (int i = 0; i < 5; i++) cyc(0, 1, 3'd3, 0, 0, 1, 1);
      check("idle_smp", 32'(smp_cnt), 32'd0);
      // start+valid together in IDLE: no sample
      cyc(1, 1, 3'd5, 1, 1, 1, 1);
      check("sv_idle_smp", 32'(smp_cnt), 32'd0);
      // random traffic
      for (int i = 0; i < 200; i++) begin
         k  = 5'($urandom_range(0, 31));
         rs = ($urandom_range(0, 7) == 0);
         rv = 1'($urandom_range(0, 1));
         rf = ($urandom_range(0, 5) == 0);
         rl = ($urandom_range(0, 15) == 0);
         cyc(rs, rv, k[4:2], k[1], k[0], rf, rl);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/gate_response_checker.md
GATE_RESPONSE_CHECKER -- requirements
Module: gate_response_checker

Interface
REQ-001 The block SHALL have parameter ERR_W, default 6, giving the width of the mismatch counter.
REQ-002 The block SHALL have parameter N_VEC, default 32, giving the number of samples that ends a run.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE.
REQ-006 valid  input  1  the current sel/a/b/out tuple is a sample.
REQ-007 sel  input  3  gate select presented to the gate under test.
REQ-008 a, b  input  1 each  gate operands presented to the gate under test.
REQ-009 out  input  1  gate-under-test response to sel/a/b.
REQ-010 last  input  1  qualified by valid; marks the final sample of a run.
REQ-011 busy  output  1  high while in RUN.
REQ-012 done  output  1  high while in DONE.
REQ-013 pass  output  1  valid only while done is high.
REQ-014 err_cnt  output  ERR_W  number of mismatches seen, saturating.
REQ-015 smp_cnt  output  6  number of samples accepted in the current or last run.
REQ-016 mismatch  output  1  registered one-cycle flag for the previous sample.

Function
REQ-017 Expected value SHALL follow this select map: 000 NAND, 001 AND, 010 OR, 011 NOR, 100 XOR, 101 XNOR, 110 NOT a, 111 NOT a.
REQ-018 The FSM SHALL have states IDLE, RUN and DONE, encoded as 2 bits.
REQ-019 IDLE SHALL go to RUN on start; counters and mismatch clear in that same edge.
REQ-020 In RUN, each cycle with valid high SHALL sample one tuple; cycles with valid low SHALL leave all state unchanged.
REQ-021 When out differs from the expected value on a sample, err_cnt SHALL increment by 1, saturating at 2^ERR_W-1.
REQ-022 On a sample, mismatch SHALL assert for exactly the next cycle; latency is 1 clock from sample to flag.
REQ-023 smp_cnt SHALL increment on each sample and SHALL saturate at N_VEC.
REQ-024 RUN SHALL go to DONE on the edge that accepts a sample when either last is high or the sample is number N_VEC.
- That final sample is counted and checked before the transition.
REQ-025 start asserted in RUN SHALL be ignored.
REQ-026 valid asserted in IDLE or DONE SHALL be ignored.
REQ-027 DONE SHALL hold err_cnt, smp_cnt and pass stable until start or rst.
REQ-028 start in DONE SHALL clear the counters and re-enter RUN on the same edge.
REQ-029 pass SHALL be 1 in DONE iff err_cnt==0 and smp_cnt>0 (plus REQ-034 when enabled); pass SHALL be 0 outside DONE.
REQ-030 A start and valid arriving in the same IDLE cycle SHALL start the run but SHALL NOT sample that tuple.

Reset
REQ-031 rst SHALL force, immediately and independent of clk: state IDLE, busy 0, done 0, pass 0, err_cnt 0, smp_cnt 0, mismatch 0 and cov_map 0.
REQ-032 rst asserted mid-RUN SHALL abandon the run with no DONE indication; after release the block waits in IDLE for start.

Configuration
REQ-033 The macro CHECKER_COVERAGE_EN SHALL add output cov_map[31:0].
- Bit {sel,a,b} is set on every sample.
- All bits clear on start and on rst.
REQ-034 With CHECKER_COVERAGE_EN defined, pass SHALL additionally require cov_map==32'hFFFF_FFFF.
REQ-035 Without CHECKER_COVERAGE_EN, port cov_map and its logic SHALL be absent and pass SHALL follow REQ-029 only.

Verification
REQ-036 Start, then 32 exhaustive correct samples {sel,a,b}=0..31 with one valid per cycle -> done 1, pass 1, err_cnt 0, smp_cnt 32; with the macro, cov_map FFFF_FFFF.
REQ-037 Same sweep but out inverted at sel=100, a=1, b=0 -> mismatch pulses once, 1 cycle later; final err_cnt 1, pass 0.
REQ-038 Every out inverted over 32 samples, ERR_W=4 -> err_cnt saturates at 15, pass 0.
REQ-039 Start, 5 correct samples with last on the 5th -> done after sample 5, smp_cnt 5, pass 1; with the macro, pass 0 due to coverage.
REQ-040 rst pulsed after 10 samples, then valid without start -> all outputs 0, state IDLE, samples ignored.
REQ-041 start in RUN and valid gaps between samples -> counts unaffected; start in DONE -> counters 0 and busy 1 on the next edge.
